// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 arbitrated output mux.
// Mode encodings and the wrap-around index helper.
package mux_pkg;

   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR  = 1'b1;

   function automatic int unsigned wrap_inc(
      input int unsigned idx,
      input int unsigned n
   );
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_arb_nx1_rr.sv
// Round-robin arbiter: owns the priority pointer and
// searches ptr+1, ptr+2, ... mod N for the first request.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   localparam int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [SW-1:0] gnt_idx,
   output logic          gnt_v
);

   logic [SW-1:0] ptr_q;
   logic [SW-1:0] ptr_d;

   always_comb begin
      logic [SW-1:0] idx;
      logic          found;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = ptr_q;
      for (int o = 0; o < N; o++) begin
         idx = SW'(wrap_inc(32'(idx), 32'(N)));
         if (!found && req[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign gnt_v = |req;

   // The granted channel becomes lowest priority for the next search.
   assign ptr_d = adv ? gnt_idx : ptr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= SW'(N - 1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 channel mux with manual or round-robin selection and a
// registered valid/ready output stage.
module mux_arb_nx1
   import mux_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int W  = 8,
   localparam int SW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           mode,
   input  logic [SW-1:0]  S,
   input  logic [N*W-1:0] i_data,
   input  logic [N-1:0]   i_valid,
   output logic [N-1:0]   i_ready,
   output logic [W-1:0]   Y,
   output logic           y_valid,
   input  logic           y_ready,
   output logic [SW-1:0]  y_src
);

   logic          ld;
   logic          rr_mode;
   logic [SW-1:0] rr_idx;
   logic          rr_v;
   logic          sel_v;
   logic [SW-1:0] g;
   logic          gnt_v;
   logic          xfer;
   logic [W-1:0]  g_data;

   logic [W-1:0]  y_q;
   logic [W-1:0]  y_d;
   logic [SW-1:0] src_q;
   logic [SW-1:0] src_d;
   logic          vld_q;
   logic          vld_d;

   assign rr_mode = (mode == MODE_RR);
   assign ld      = !vld_q || y_ready;
   assign xfer    = ld && gnt_v;

   rr_arbiter #(
      .N (N)
   ) u_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (i_valid),
      .adv     (xfer && rr_mode),
      .gnt_idx (rr_idx),
      .gnt_v   (rr_v)
   );

   // An out-of-range S never matches a channel, so it yields no grant.
   always_comb begin
      sel_v = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (S == SW'(k)) begin
            sel_v = i_valid[k];
         end
      end
   end

   assign g     = rr_mode ? rr_idx : S;
   assign gnt_v = rr_mode ? rr_v : sel_v;

   always_comb begin
      g_data = '0;
      for (int k = 0; k < N; k++) begin
         if (g == SW'(k)) begin
            g_data = i_data[k*W +: W];
         end
      end
   end

   always_comb begin
      i_ready = '0;
      for (int k = 0; k < N; k++) begin
         i_ready[k] = xfer && (g == SW'(k));
      end
   end

   always_comb begin
      y_d   = y_q;
      src_d = src_q;
      vld_d = vld_q;
      if (ld) begin
         vld_d = gnt_v;
         if (gnt_v) begin
            y_d   = g_data;
            src_d = g;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q   <= '0;
         src_q <= '0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         src_q <= src_d;
         vld_q <= vld_d;
      end
   end

   assign Y       = y_q;
   assign y_src   = src_q;
   assign y_valid = vld_q;

   a_ready_onehot : assert property (
      @(posedge clk) disable iff (rst) $onehot0(i_ready)
   );

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1 (N=4, W=8): directed
// vector table, async reset check and a scoreboarded random soak.
module tb_mux_arb_nx1;

   localparam int N = 4;
   localparam int W = 8;

   logic          clk;
   logic          rst;
   logic          mode;
   logic [1:0]    S;
   logic [31:0]   i_data;
   logic [3:0]    i_valid;
   logic [3:0]    i_ready;
   logic [7:0]    Y;
   logic          y_valid;
   logic          y_ready;
   logic [1:0]    y_src;

   mux_arb_nx1 #(
      .N (N),
      .W (W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode),
      .S       (S),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .Y       (Y),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y_src   (y_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [7:0] d;
      logic [1:0] s;
   } item_t;

   item_t sb[$];
   int    ptr_m;
   int    wt[N];
   int    max_wait;

   // Reference model + scoreboard, evaluated mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         ptr_m = N - 1;
         for (int k = 0; k < N; k++) wt[k] = 0;
      end else begin
         logic       qv;
         logic       ldm;
         logic       gvm;
         int         gm;
         logic [3:0] exp_rdy;
         item_t      it;
         qv = (sb.size() != 0);
         check("y_valid_mon", {31'd0, y_valid}, {31'd0, qv});
         ldm = !qv || y_ready;
         gm  = 0;
         gvm = 1'b0;
         if (mode) begin
            for (int o = 1; o <= N; o++) begin
               int c;
               c = (ptr_m + o) % N;
               if (!gvm && i_valid[c]) begin
                  gvm = 1'b1;
                  gm  = c;
               end
            end
         end else begin
            gm  = int'(S);
            gvm = i_valid[gm];
         end
         exp_rdy = (ldm && gvm) ? 4'(1 << gm) : 4'd0;
         check("i_ready_mon", {28'd0, i_ready}, {28'd0, exp_rdy});
         if (qv && y_ready) begin
            it = sb.pop_front();
            check("Y_sb", {24'd0, Y}, {24'd0, it.d});
            check("y_src_sb", {30'd0, y_src}, {30'd0, it.s});
         end
         if (ldm && gvm) begin
            it.d = i_data[gm*8 +: 8];
            it.s = 2'(gm);
            sb.push_back(it);
            if (mode) ptr_m = gm;
         end
         for (int k = 0; k < N; k++) begin
            if (!mode || !i_valid[k]) begin
               wt[k] = 0;
            end else if (ldm && gvm) begin
               if (k == gm) wt[k] = 0;
               else wt[k]++;
            end
            if (wt[k] > max_wait) max_wait = wt[k];
         end
      end
   end

   typedef struct {
      logic       m;
      logic [1:0] s;
      logic [31:0] d;
      logic [3:0] v;
      logic       yr;
      logic [3:0] ir;
      logic       yv;
      logic [7:0] y;
      logic [1:0] src;
   } vec_t;

   localparam logic [31:0] DA = 32'h13A5_1110;
   localparam logic [31:0] DR = 32'h1312_1110;

   vec_t tv[18];

   initial begin
      tv[0]  = '{1'b0, 2'd2, DA, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
      tv[1]  = '{1'b0, 2'd1, DA, 4'b0100, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tv[2]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tv[3]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
      tv[4]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
      tv[5]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tv[6]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tv[7]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
      tv[8]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
      tv[9]  = '{1'b1, 2'd0, DR, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
      tv[10] = '{1'b1, 2'd0, DR, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
      tv[11] = '{1'b1, 2'd0, DR, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
      tv[12] = '{1'b1, 2'd0, DR, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tv[13] = '{1'b1, 2'd0, DR, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tv[14] = '{1'b1, 2'd0, DR, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tv[15] = '{1'b1, 2'd0, DR, 4'b1001, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
      tv[16] = '{1'b1, 2'd0, DR, 4'b1001, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
      tv[17] = '{1'b1, 2'd0, DR, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

      max_wait = 0;
      rst     = 1'b1;
      mode    = 1'b0;
      S       = 2'd0;
      i_data  = '0;
      i_valid = '0;
      y_ready = 1'b0;
      #2;
      check("rst_y_valid", {31'd0, y_valid}, 32'd0);
      check("rst_Y", {24'd0, Y}, 32'd0);
      check("rst_y_src", {30'd0, y_src}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         mode    = tv[i].m;
         S       = tv[i].s;
         i_data  = tv[i].d;
         i_valid = tv[i].v;
         y_ready = tv[i].yr;
         @(negedge clk);
         check($sformatf("v%0d_i_ready", i), {28'd0, i_ready},
               {28'd0, tv[i].ir});
         @(posedge clk);
         #1;
         check($sformatf("v%0d_y_valid", i), {31'd0, y_valid},
               {31'd0, tv[i].yv});
         if (tv[i].yv) begin
            check($sformatf("v%0d_Y", i), {24'd0, Y}, {24'd0, tv[i].y});
            check($sformatf("v%0d_y_src", i), {30'd0, y_src},
                  {30'd0, tv[i].src});
         end
      end

      // Async reset during a stall must clear the word without an edge.
      mode    = 1'b1;
      i_data  = 32'h4433_2211;
      i_valid = 4'b0010;
      y_ready = 1'b1;
      @(posedge clk);
      #1;
      check("pre_rst_y_valid", {31'd0, y_valid}, 32'd1);
      i_valid = 4'b0000;
      y_ready = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("mid_rst_y_valid", {31'd0, y_valid}, 32'd0);
      check("mid_rst_Y", {24'd0, Y}, 32'd0);
      check("mid_rst_y_src", {30'd0, y_src}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      i_data  = DR;
      i_valid = 4'b1111;
      y_ready = 1'b1;
      @(negedge clk);
      check("post_rst_rr_first", {28'd0, i_ready}, 32'd1);
      @(posedge clk);
      #1;

      for (int c = 0; c < 1000; c++) begin
         mode    = ($urandom_range(0, 3) != 0);
         S       = 2'($urandom_range(0, 3));
         i_valid = 4'($urandom_range(0, 15));
         y_ready = ($urandom_range(0, 3) != 0);
         i_data  = $urandom;
         @(posedge clk);
         #1;
      end

      i_valid = 4'b0000;
      y_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("sb_empty", 32'(sb.size()), 32'd0);
      check("rr_starvation", {31'd0, (max_wait <= N - 1)}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_arb_nx1.md
Name: mux_arb_nx1

Overview:
- Parametrised successor to the 2:1 combinational mux.
- Selects one of N input channels of W bits each and drives a registered, valid/ready-handshaked output.
- Two selection modes: manual select (S) and round-robin arbitration among valid channels.
- Sits between multiple producer streams and a single consumer; output is back-pressure safe.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel (W >= 1).
- SW, $clog2(N), select/source index width (localparam, derived; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = manual select via S, 1 = round-robin.
- S  in  SW  channel select, used in mode 0 only.
- i_data  in  N*W  packed channel data; channel k occupies bits [k*W +: W].
- i_valid  in  N  per-channel valid.
- i_ready  out  N  per-channel ready; combinational; at most one bit high.
- Y  out  W  registered output data.
- y_valid  out  1  output holds valid data.
- y_ready  in  1  consumer accepts Y this cycle.
- y_src  out  SW  index of the channel that supplied the current Y.

Behaviour:
- Reset (async assert, sync release is the integrator's concern):
  - Y=0, y_valid=0, y_src=0.
  - Round-robin pointer ptr=N-1, so the first RR grant prefers channel 0.
- Load enable:
  - ld = !y_valid || y_ready.
  - Output register accepts a new word only when ld=1.
- Grant (combinational):
  - mode 0: grant g=S, gnt_v = (S<N) && i_valid[S]. S>=N (N not a power of 2) gives no grant.
  - mode 1: g = first k with i_valid[k]=1, searching ptr+1, ptr+2, ... mod N. gnt_v = |i_valid.
- i_ready[g] = ld && gnt_v; all other i_ready bits are 0.
  - i_ready must not depend on i_valid of channels other than through grant selection.
- Transfer (ld && gnt_v) at the clock edge:
  - Y<=i_data[g], y_src<=g, y_valid<=1.
  - ptr<=g (updated in mode 1 only; held in mode 0).
- Drain: ld && !gnt_v gives y_valid<=0. Y and y_src hold their last value (don't-care).
- Stall: y_valid && !y_ready means Y, y_src, y_valid and ptr are held, and all i_ready are 0.
- Latency and throughput:
  - Input transfer to Y visible: 1 cycle.
  - Sustained throughput: 1 word/cycle when y_ready is held high.
- Fairness (mode 1): any channel held valid is granted within N transfers.
  - Last-granted channel is lowest priority next time.
- Mode switch: takes effect on the next grant evaluation. ptr is preserved across mode 0 periods.
- Simultaneous y_ready and new grant in the same cycle: old word leaves and new word loads. No bubble.
- Reset mid-stall: word is discarded, y_valid=0 immediately (async).

Decomposition:
- Shared package mux_pkg:
  - MODE_SEL=1'b0, MODE_RR=1'b1.
  - Function for wrap-around index increment mod N.
- Sub-module rr_arbiter: owns ptr and the rotating priority search.
  - Inputs: clk, rst, req[N], adv (= ld && gnt_v && mode).
  - Outputs: gnt_idx[SW], gnt_v.
- Top instantiates rr_arbiter, plus the mode mux, output register and handshake logic.

Test Plan (N=4, W=8):
- Reset: assert rst mid-stream with y_valid=1 -> y_valid, Y and y_src go to 0 immediately, without waiting for a clock edge.
- Manual mode:
  - mode=0, S=2, i_data ch2=8'hA5, i_valid=4'b0100, y_ready=1 -> i_ready=4'b0100; next cycle Y=8'hA5, y_src=2, y_valid=1.
  - S=1 with i_valid=4'b0100 -> i_ready=0 and y_valid drops to 0.
- Round-robin fairness: mode=1, i_valid=4'b1111 held, y_ready=1, data ch k = 8'h10+k -> y_src sequence 0,1,2,3,0 on consecutive cycles; Y=8'h10,8'h11,8'h12,8'h13,8'h10.
- Back-pressure: after Y=8'h11 loaded, y_ready=0 for 3 cycles -> Y=8'h11 and y_src=1 stable, i_ready=4'b0000. y_ready=1 -> next word is ch2 (8'h12), no loss or duplication.
- Sparse RR with wrap: i_valid=4'b1001, ptr at 3 -> grants alternate 0,3,0,3; channels 1 and 2 never get i_ready.
- Random soak (1000 cycles, random i_valid/y_ready/mode):
  - Scoreboard: every accepted input appears exactly once, in order, on Y with the correct y_src.
  - No channel is starved beyond 4 transfers in mode 1.
